// File: rtl/rr_arb_mux2.sv
// Two-input round-robin arbiter feeding a one-entry registered output stage.
// The loser of each transfer holds priority for the next contended cycle.
module rr_arb_mux2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d0_valid,
  input  logic [WIDTH-1:0] d0_data,
  output logic             d0_ready,
  input  logic             d1_valid,
  input  logic [WIDTH-1:0] d1_data,
  output logic             d1_ready,
  output logic             sel,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_src,
  input  logic             y_ready
);

  logic r_pri;
  logic w_space;
  logic w_load;

  // Winner depends only on the valids and the pointer, never on y_ready.
  always_comb begin
    sel = r_pri;
    if (d0_valid && !d1_valid) begin
      sel = 1'b0;
    end else if (d1_valid && !d0_valid) begin
      sel = 1'b1;
    end else begin
      sel = r_pri;
    end
  end

  assign w_space  = !y_valid || y_ready;
  assign d0_ready = w_space && d0_valid && (sel == 1'b0);
  assign d1_ready = w_space && d1_valid && (sel == 1'b1);
  assign w_load   = d0_ready || d1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      y_data  <= {WIDTH{1'b0}};
      y_src   <= 1'b0;
      r_pri   <= 1'b0;
    end else if (w_load) begin
      y_valid <= 1'b1;
      y_data  <= sel ? d1_data : d0_data;
      y_src   <= sel;
      r_pri   <= ~sel;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end else begin
      y_valid <= y_valid;
    end
  end

endmodule
